// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M/RV64M multiply/divide unit for the EX stage.
//
// Accepts one M-extension op from ID/EX. It iterates one bit per cycle and
// holds the pipeline through stall_req until the result is ready.
// Divide-by-zero and signed-overflow divides skip the iteration and
// finish on the next edge.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      issue request, only looked at in IDLE
//   op         RISC-V funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   op_a/op_b  rs1/rs2 operands, captured together with start
//   cancel     pipeline flush, aborts an op in flight
//   result     registered result, held until replaced by a later op
//   done       one-cycle pulse when result is valid
//   busy       high while in CALC or DONE
//   stall_req  holds IF/ID/EX while an op is being accepted or computed
module ex_muldiv #(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            cancel,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            stall_req
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [2:0]          r_op;
    logic                r_neg;
    logic                r_remNeg;
    logic [XLEN-1:0]     r_opnd;
    logic [2*XLEN-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN-1:0]     r_result;
    logic                r_done;

    logic                w_signA;
    logic                w_signB;
    logic                w_negA;
    logic                w_negB;
    logic [XLEN-1:0]     w_magA;
    logic [XLEN-1:0]     w_magB;
    logic                w_divZero;
    logic                w_ovf;
    logic                w_fast;
    logic [XLEN-1:0]     w_fastRes;
    logic [XLEN:0]       w_mulSum;
    logic [2*XLEN-1:0]   w_mulNext;
    logic [XLEN:0]       w_remSh;
    logic [XLEN:0]       w_diff;
    logic [2*XLEN-1:0]   w_divNext;
    logic [2*XLEN-1:0]   w_accNext;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_final;
    logic                w_lastIter;

    // Operand sign decode on the issuing op; magnitudes are what gets iterated.
    always_comb begin
        w_signA   = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        w_signB   = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        w_negA    = w_signA && op_a[XLEN-1];
        w_negB    = w_signB && op_b[XLEN-1];
        w_magA    = w_negA ? -op_a : op_a;
        w_magB    = w_negB ? -op_b : op_b;
        w_divZero = op[2] && (op_b == '0);
        w_ovf     = ((op == 3'b100) || (op == 3'b110)) &&
                    (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        w_fast    = w_divZero || w_ovf;
        // op[1] distinguishes REM/REMU from DIV/DIVU
        if (w_divZero) begin
            w_fastRes = op[1] ? op_a : '1;
        end else begin
            w_fastRes = op[1] ? '0 : op_a;
        end
    end

    // One iteration step. Multiply shifts the product right through the
    // accumulator and adds the multiplicand into the upper half. Divide
    // keeps {remainder, quotient} and does a restoring subtract.
    always_comb begin
        w_mulSum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_mulNext = {w_mulSum, r_acc[XLEN-1:1]};
        w_remSh   = r_acc[2*XLEN-1:XLEN-1];
        w_diff    = w_remSh - {1'b0, r_opnd};
        if (w_diff[XLEN]) begin
            w_divNext = {w_remSh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        end else begin
            w_divNext = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end
        w_accNext = r_op[2] ? w_divNext : w_mulNext;
    end

    // Sign correction and word selection applied to the final iteration.
    always_comb begin
        w_prod = r_neg ? -w_accNext : w_accNext;
        w_quo  = r_neg ? -w_accNext[XLEN-1:0] : w_accNext[XLEN-1:0];
        w_rem  = r_remNeg ? -w_accNext[2*XLEN-1:XLEN] : w_accNext[2*XLEN-1:XLEN];
        case (r_op)
            3'b000:                 w_final = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_quo;
            default:                w_final = w_rem;
        endcase
        w_lastIter = (r_cnt == CNT_W'(XLEN - 1));
    end

    // Control FSM. A cancel in CALC drops the op without touching result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_remNeg <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        r_op     <= op;
                        r_neg    <= w_negA ^ w_negB;
                        r_remNeg <= w_negA;
                        r_opnd   <= op[2] ? w_magB : w_magA;
                        r_acc    <= {{XLEN{1'b0}}, (op[2] ? w_magA : w_magB)};
                        r_cnt    <= '0;
                        if (w_fast) begin
                            r_result <= w_fastRes;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_accNext;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_lastIter) begin
                            r_result <= w_final;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign result    = r_result;
    assign done      = r_done;
    assign busy      = (r_state != S_IDLE);
    // Raised combinationally in the issue cycle so the op stays in EX.
    assign stall_req = !rst && (((r_state == S_IDLE) && start && !cancel) ||
                                (r_state == S_CALC));

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: self-checking bench for ex_muldiv (XLEN=32).
// Inputs are driven on the falling edge and outputs are sampled 1ns later.
// Cycle 0 is the cycle in which start is presented.
module tb_ex_muldiv;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic            cancel;
    logic [XLEN-1:0] result;
    logic            done;
    logic            busy;
    logic            stall_req;

    int checks = 0;
    int errors = 0;

    ex_muldiv #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .op_a      (opA),
        .op_b      (opB),
        .cancel    (cancel),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    // Reference model straight from the RISC-V M-extension definitions.
    function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        int          ia;
        int          ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
        if (o[2] && b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Issues one op and reports its result, the cycle done was seen in
    // (-1 on timeout) and how many cycles had a wrong stall_req.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] res,
                                 output int lat, output int stallBad);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        opA    = a;
        opB    = b;
        cancel = 1'b0;
        #1;
        stallBad = (stall_req !== 1'b1) ? 1 : 0;
        lat = -1;
        res = 'x;
        for (int c = 1; c <= XLEN + 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done === 1'b1) begin
                lat = c;
                res = result;
                if (stall_req !== 1'b0) stallBad++;
                break;
            end else if (stall_req !== 1'b1) begin
                stallBad++;
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b1;
        cancel = 1'b0;
        op     = 3'd0;
        opA    = 32'd5;
        opB    = 32'd6;
        #3;
        checks++;
        if (result !== 32'h0 || done !== 1'b0 || busy !== 1'b0 || stall_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got result=%h done=%b busy=%b stall=%b expected all zero",
                     result, done, busy, stall_req);
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  tOp [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                  3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] tA  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                  32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] tB  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'd2, 32'd2, 32'd7, 32'd7,
                                  32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] tExp[12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                  32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        int          tLat[12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
        logic [31:0] res;
        int          lat;
        int          stallBad;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tOp[i], tA[i], tB[i], res, lat, stallBad);
            checks++;
            if (res !== tExp[i]) begin
                errors++;
                $display("[TB] FAIL directed_result[%0d] got %h expected %h", i, res, tExp[i]);
            end
            checks++;
            if (lat !== tLat[i]) begin
                errors++;
                $display("[TB] FAIL directed_latency[%0d] got %0d expected %0d", i, lat, tLat[i]);
            end
            checks++;
            if (stallBad !== 0) begin
                errors++;
                $display("[TB] FAIL directed_stall[%0d] got %0d bad cycles expected 0", i, stallBad);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          stallBad;
        int          sel;
        for (int i = 0; i < 60; i++) begin
            o   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'h0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'($urandom_range(1, 15));
            if (sel == 3) b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            applyStimulus(o, a, b, res, lat, stallBad);
            checks++;
            if (res !== refModel(o, a, b) || lat !== refLatency(o, a, b) || stallBad !== 0) begin
                errors++;
                $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h got %h lat %0d stallBad %0d expected %h lat %0d",
                         i, o, a, b, res, lat, stallBad, refModel(o, a, b), refLatency(o, a, b));
            end
        end
    endtask

    task automatic test_cancel();
        logic [31:0] res;
        int          lat;
        int          stallBad;
        int          pulses;
        applyStimulus(3'd5, 32'd100, 32'd7, res, lat, stallBad);
        checks++;
        if (res !== 32'd14) begin
            errors++;
            $display("[TB] FAIL cancel_setup got %h expected %h", res, 32'd14);
        end
        pulses = 0;
        @(negedge clk);
        start = 1'b1;
        op    = 3'd4;
        opA   = 32'hDEAD_BEEF;
        opB   = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 10) cancel = 1'b1;
            #1;
            if (done === 1'b1) pulses++;
        end
        @(negedge clk);
        cancel = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || stall_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cancel_idle got busy=%b stall=%b expected 0 0", busy, stall_req);
        end
        checks++;
        if (result !== 32'd14) begin
            errors++;
            $display("[TB] FAIL cancel_result_hold got %h expected %h", result, 32'd14);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("[TB] FAIL cancel_no_done got %0d pulses expected 0", pulses);
        end
        applyStimulus(3'd0, 32'd3, 32'd4, res, lat, stallBad);
        checks++;
        if (res !== 32'd12 || lat !== 33) begin
            errors++;
            $display("[TB] FAIL cancel_followup got %h lat %0d expected %h lat 33", res, lat, 32'd12);
        end
    endtask

    task automatic test_start_cancel_idle();
        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        op     = 3'd0;
        opA    = 32'd9;
        opB    = 32'd9;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_cancel_stall got %b expected 0", stall_req);
        end
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_cancel_busy got %b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        a   = $urandom;
        b   = $urandom;
        lat = -1;
        res = 'x;
        @(negedge clk);
        start = 1'b1;
        op    = 3'd3;
        opA   = a;
        opB   = b;
        for (int c = 1; c <= XLEN + 8; c++) begin
            @(negedge clk);
            start = (c >= 3);
            op    = 3'd0;
            opA   = 32'h1234_5678;
            opB   = 32'h0000_0003;
            #1;
            if (done === 1'b1) begin
                lat = c;
                res = result;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (res !== refModel(3'd3, a, b) || lat !== 33) begin
            errors++;
            $display("[TB] FAIL busy_start_result got %h lat %0d expected %h lat 33",
                     res, lat, refModel(3'd3, a, b));
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_start_ignored got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          stallBad;
        int          pulses;
        @(negedge clk);
        start = 1'b1;
        op    = 3'd0;
        opA   = 32'h0001_2345;
        opB   = 32'h0000_0777;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (result !== 32'h0 || done !== 1'b0 || busy !== 1'b0 || stall_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset got result=%h done=%b busy=%b stall=%b expected all zero",
                     result, done, busy, stall_req);
        end
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("[TB] FAIL async_reset_no_done got %0d pulses expected 0", pulses);
        end
        a = $urandom;
        b = $urandom;
        applyStimulus(3'd1, a, b, res, lat, stallBad);
        checks++;
        if (res !== refModel(3'd1, a, b) || lat !== 33 || stallBad !== 0) begin
            errors++;
            $display("[TB] FAIL async_reset_fresh got %h lat %0d stallBad %0d expected %h lat 33",
                     res, lat, stallBad, refModel(3'd1, a, b));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_cancel();
        test_start_cancel_idle();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
